// File: rtl/hubris_uart_tx_drain_pkg.sv
// Shared definitions for the Hubris console-output UART drain:
// transmitter state encoding and 8N1 frame geometry.
package hubris_uart_tx_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/hubris_uart_tx_drain_uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last cycle of each bit with tick. Held at zero whenever run is low.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   logic [15:0] count;

   always_ff @(posedge clk) begin
      if (!reset || !run) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign tick = run && (count == 16'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/hubris_uart_tx_drain.sv
// Drains the Hubris output-IO byte buffer one byte at a time and transmits
// each byte as an 8N1 UART frame, with back-to-back chaining on STOP.
module hubris_uart_tx_drain
   import hubris_uart_tx_drain_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            io_buffer_size_avai,
   input  logic [7:0]             io_output_data,
   output logic                   io_output_en,
   output logic                   uart_tx,
   output logic                   busy,
   output logic                   drained,
   output logic [COUNT_WIDTH-1:0] bytes_sent
);

   localparam int IDX_W = $clog2(UART_DATA_BITS);

   tx_state_e                 state, state_next;
   logic [IDX_W-1:0]          bit_idx, bit_idx_next;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
   logic                      tx_next;
   logic                      run, tick, pop, frame_done;

   assign run = (state != IDLE);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .run  (run),
      .tick (tick)
   );

   // A pop is only offered when the line is free now or frees up this cycle.
   assign frame_done   = (state == STOP) && tick;
   assign pop          = reset && (io_buffer_size_avai != 32'd0) &&
                         ((state == IDLE) || frame_done);
   assign io_output_en = pop;
   assign busy         = run;
   assign drained      = (state == IDLE) && (io_buffer_size_avai == 32'd0);

   always_comb begin
      state_next   = state;
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;
      tx_next      = 1'b1;
      unique case (state)
         IDLE: begin
            if (pop) begin
               state_next = START;
               shift_next = io_output_data;
            end
         end
         START: begin
            if (tick) begin
               state_next   = DATA;
               bit_idx_next = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (pop) begin
                  state_next = START;
                  shift_next = io_output_data;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // The line level is registered from the upcoming state so it never glitches.
      unique case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[bit_idx_next];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         shift_reg  <= '0;
         uart_tx    <= 1'b1;
         bytes_sent <= '0;
      end else begin
         state     <= state_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         uart_tx   <= tx_next;
         if (frame_done) begin
            bytes_sent <= bytes_sent + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_hubris_uart_tx_drain.sv
// Bench for hubris_uart_tx_drain: a frame-level reference model checks two
// instances every cycle, alongside directed tables and corner-case sequences.
module tb_hubris_uart_tx_drain;

   localparam int CA   = 4;
   localparam int CB   = 2;
   localparam int HIST = 16384;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] avai_a, avai_b;
   logic [7:0]  data_a, data_b;
   logic        en_a, tx_a, busy_a, drained_a;
   logic        en_b, tx_b, busy_b, drained_b;
   logic [31:0] bytes_a;
   logic [3:0]  bytes_b;

   always #5 clk = ~clk;

   hubris_uart_tx_drain #(.CLKS_PER_BIT(CA), .COUNT_WIDTH(32)) dut_a (
      .clk(clk), .reset(reset), .io_buffer_size_avai(avai_a), .io_output_data(data_a),
      .io_output_en(en_a), .uart_tx(tx_a), .busy(busy_a), .drained(drained_a),
      .bytes_sent(bytes_a));

   hubris_uart_tx_drain #(.CLKS_PER_BIT(CB), .COUNT_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .io_buffer_size_avai(avai_b), .io_output_data(data_b),
      .io_output_en(en_b), .uart_tx(tx_b), .busy(busy_b), .drained(drained_b),
      .bytes_sent(bytes_b));

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   bit         hold_a = 0, hold_b = 0;
   bit         pop_a = 0, pop_b = 0;
   bit         mon_en = 0;
   int         n_checks = 0, n_pass = 0;
   int         cyc = 0;
   int         pop_cyc_a[$];
   int         pop_cyc_b[$];
   logic       tx_hist_a [HIST];
   logic       busy_hist_a [HIST];
   vec_t       tbl [6];

   // Reference model: position inside the current frame, counted in clocks.
   bit         m_in  [2] = '{0, 0};
   int         m_t   [2] = '{0, 0};
   logic [7:0] m_cur [2] = '{8'h00, 8'h00};
   longint     m_cnt [2] = '{0, 0};
   int         m_c   [2] = '{CA, CB};
   longint     m_mod [2] = '{64'h1_0000_0000, 64'd16};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i >= 9) return 1'b1;
      return b[i-1];
   endfunction

   always @(negedge clk) begin
      logic [31:0] av;
      logic [7:0]  dv;
      logic        en, tx, bz, dr, xe, xtx;
      longint      bs;
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
               av = avai_a; dv = data_a; en = en_a; tx = tx_a; bz = busy_a; dr = drained_a; bs = longint'(bytes_a);
            end else begin
               av = avai_b; dv = data_b; en = en_b; tx = tx_b; bz = busy_b; dr = drained_b; bs = longint'(bytes_b);
            end
            xe  = reset && (av != 0) && (!m_in[k] || m_t[k] == 10 * m_c[k] - 1);
            xtx = m_in[k] ? frame_bit(m_cur[k], m_t[k] / m_c[k]) : 1'b1;
            check(k == 0 ? "a_en" : "b_en", en, xe);
            check(k == 0 ? "a_tx" : "b_tx", tx, xtx);
            check(k == 0 ? "a_busy" : "b_busy", bz, m_in[k]);
            check(k == 0 ? "a_drained" : "b_drained", dr, !m_in[k] && av == 0);
            check(k == 0 ? "a_bytes" : "b_bytes", bs, m_cnt[k]);
            if (!reset) begin
               m_in[k] = 0; m_t[k] = 0; m_cnt[k] = 0;
            end else if (m_in[k] && m_t[k] == 10 * m_c[k] - 1) begin
               m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
               if (xe) begin m_t[k] = 0; m_cur[k] = dv; end
               else m_in[k] = 0;
            end else if (m_in[k]) begin
               m_t[k]++;
            end else if (xe) begin
               m_in[k] = 1; m_t[k] = 0; m_cur[k] = dv;
            end
         end
      end
      pop_a = en_a;
      pop_b = en_b;
      if (en_a) pop_cyc_a.push_back(cyc);
      if (en_b) pop_cyc_b.push_back(cyc);
      tx_hist_a[cyc % HIST]   = tx_a;
      busy_hist_a[cyc % HIST] = busy_a;
      cyc++;
   end

   task automatic apply();
      avai_a = hold_a ? 32'd0 : 32'(q_a.size());
      data_a = (q_a.size() > 0) ? q_a[0] : 8'($urandom);
      avai_b = hold_b ? 32'd0 : 32'(q_b.size());
      data_b = (q_b.size() > 0) ? q_b[0] : 8'($urandom);
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      #1;
      if (pop_a && q_a.size() > 0) void'(q_a.pop_front());
      if (pop_b && q_b.size() > 0) void'(q_b.pop_front());
      apply();
      #1;
   endtask

   task automatic wait_pops(input int k, input int n, input int budget, input string name);
      int target, left;
      target = ((k == 0) ? pop_cyc_a.size() : pop_cyc_b.size()) + n;
      left   = budget;
      while (((k == 0) ? pop_cyc_a.size() : pop_cyc_b.size()) < target && left > 0) begin
         tick_cycle();
         left--;
      end
      check(name, ((k == 0) ? pop_cyc_a.size() : pop_cyc_b.size()) >= target, 1);
   endtask

   task automatic wait_drained(input int k, input int budget, input string name);
      int left;
      left = budget;
      while (!((k == 0) ? drained_a : drained_b) && left > 0) begin
         tick_cycle();
         left--;
      end
      check(name, (k == 0) ? drained_a : drained_b, 1);
   endtask

   function automatic logic [9:0] frame_word(input int pc);
      logic [9:0] w;
      for (int i = 0; i < 10; i++) w[i] = tx_hist_a[(pc + 1 + i * CA + CA / 2) % HIST];
      return w;
   endfunction

   function automatic int busy_sum(input int from, input int to);
      int s;
      s = 0;
      for (int i = from; i <= to; i++) s += int'(busy_hist_a[i % HIST]);
      return s;
   endfunction

   initial begin
      int pc, pc2, b0, np, cnt_en, cnt_low, cnt_busy, cnt_nd, bad, exp_cyc;

      tbl[0] = '{8'h41, 10'h282};
      tbl[1] = '{8'h00, 10'h200};
      tbl[2] = '{8'hFF, 10'h3FE};
      tbl[3] = '{8'h55, 10'h2AA};
      tbl[4] = '{8'hAA, 10'h354};
      tbl[5] = '{8'h3C, 10'h278};

      // Reset state, with a byte waiting so io_output_en must be masked.
      reset = 1'b0;
      apply();
      @(posedge clk);
      #1;
      mon_en = 1;
      tick_cycle();
      q_a.push_back(8'h77);
      apply();
      #1;
      check("rst_en_masked", en_a, 0);
      check("rst_tx", tx_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_bytes", bytes_a, 0);
      q_a.delete();
      apply();
      tick_cycle();
      reset = 1'b1;

      // Empty buffer for 200 clocks.
      np = pop_cyc_a.size();
      cnt_en = 0; cnt_low = 0; cnt_busy = 0; cnt_nd = 0;
      for (int i = 0; i < 200; i++) begin
         tick_cycle();
         cnt_en   += int'(en_a);
         cnt_low  += int'(!tx_a);
         cnt_busy += int'(busy_a);
         cnt_nd   += int'(!drained_a);
      end
      check("empty_en_cycles", cnt_en, 0);
      check("empty_pops", pop_cyc_a.size() - np, 0);
      check("empty_tx_low_cycles", cnt_low, 0);
      check("empty_busy_cycles", cnt_busy, 0);
      check("empty_not_drained_cycles", cnt_nd, 0);

      // Single frames from the vector table.
      for (int r = 0; r < 6; r++) begin
         b0 = bytes_a;
         np = pop_cyc_a.size();
         q_a.push_back(tbl[r].data);
         apply();
         wait_pops(0, 1, 10, "tbl_pop_timeout");
         pc = pop_cyc_a[$];
         wait_drained(0, 100, "tbl_drain_timeout");
         repeat (6) tick_cycle();
         check($sformatf("tbl%0d_frame", r), frame_word(pc), tbl[r].frame);
         check($sformatf("tbl%0d_busy_cycles", r), busy_sum(pc + 1, pc + 45), 40);
         check($sformatf("tbl%0d_pop_count", r), pop_cyc_a.size() - np, 1);
         check($sformatf("tbl%0d_bytes", r), bytes_a, b0 + 1);
         check($sformatf("tbl%0d_drained", r), drained_a, 1);
      end

      // Two bytes back-to-back: no idle gap between frames.
      b0 = bytes_a;
      q_a.push_back(8'h55);
      q_a.push_back(8'hAA);
      apply();
      wait_pops(0, 2, 100, "b2b_pop_timeout");
      pc2 = pop_cyc_a[$];
      pc  = pop_cyc_a[$-1];
      wait_drained(0, 200, "b2b_drain_timeout");
      repeat (6) tick_cycle();
      check("b2b_pop_spacing", pc2 - pc, 40);
      check("b2b_busy_cycles", busy_sum(pc + 1, pc + 85), 80);
      check("b2b_frame0", frame_word(pc), 10'h2AA);
      check("b2b_frame1", frame_word(pc2), 10'h354);
      check("b2b_bytes", bytes_a, b0 + 2);

      // Buffer count drops mid-frame, then returns after 100 clocks.
      q_a.push_back(8'h11);
      apply();
      wait_pops(0, 1, 10, "hold_pop_timeout");
      pc = pop_cyc_a[$];
      q_a.push_back(8'h22);
      apply();
      repeat (10) tick_cycle();
      hold_a = 1;
      apply();
      wait_drained(0, 100, "hold_drain_timeout");
      check("hold_idle_busy", busy_a, 0);
      np = pop_cyc_a.size();
      repeat (100) tick_cycle();
      check("hold_no_pop", pop_cyc_a.size() - np, 0);
      check("hold_frame", frame_word(pc), 10'h222);
      hold_a = 0;
      apply();
      #1;
      check("hold_release_en", en_a, 1);
      exp_cyc = cyc;
      tick_cycle();
      check("hold_release_pop_cycle", (pop_cyc_a.size() > np) ? pop_cyc_a[$] : -1, exp_cyc);
      wait_drained(0, 100, "hold_final_drain_timeout");

      // Reset during DATA bit 3 of a frame, with another byte pending.
      q_a.push_back(8'h96);
      apply();
      wait_pops(0, 1, 10, "rstmid_pop_timeout");
      pc = pop_cyc_a[$];
      q_a.push_back(8'h5A);
      apply();
      while (cyc < pc + 18) tick_cycle();
      check("rstmid_busy_before", busy_a, 1);
      reset = 1'b0;
      #1;
      check("rstmid_en_masked", en_a, 0);
      tick_cycle();
      check("rstmid_tx_after", tx_a, 1);
      check("rstmid_busy_after", busy_a, 0);
      check("rstmid_bytes_after", bytes_a, 0);
      check("rstmid_en_held", en_a, 0);
      tick_cycle();
      check("rstmid_en_held2", en_a, 0);
      reset = 1'b1;
      wait_pops(0, 1, 10, "rstmid_fresh_pop_timeout");
      pc = pop_cyc_a[$];
      wait_drained(0, 100, "rstmid_drain_timeout");
      repeat (2) tick_cycle();
      check("rstmid_fresh_frame", frame_word(pc), 10'h2B4);
      check("rstmid_fresh_bytes", bytes_a, 1);

      // 4-bit counter wrap on the fast instance: 17 chained 20-clock frames.
      check("wrap_start_bytes", bytes_b, 0);
      np = pop_cyc_b.size();
      for (int i = 0; i < 17; i++) q_b.push_back(8'($urandom));
      apply();
      wait_pops(1, 17, 400, "wrap_pop_timeout");
      bad = 0;
      for (int i = np + 1; i < pop_cyc_b.size(); i++)
         if (pop_cyc_b[i] - pop_cyc_b[i-1] != 20) bad++;
      check("wrap_bad_spacings", bad, 0);
      wait_drained(1, 100, "wrap_drain_timeout");
      check("wrap_bytes", bytes_b, 1);

      // Randomised traffic, buffer stalls and resets against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0 && q_a.size() < 4) q_a.push_back(8'($urandom));
         if ($urandom_range(4) == 0 && q_b.size() < 4) q_b.push_back(8'($urandom));
         if ($urandom_range(39) == 0) hold_a = !hold_a;
         if ($urandom_range(39) == 0) hold_b = !hold_b;
         if (reset && $urandom_range(499) == 0) reset = 1'b0;
         else if (!reset && $urandom_range(2) == 0) reset = 1'b1;
         apply();
         tick_cycle();
      end
      reset  = 1'b1;
      hold_a = 0;
      hold_b = 0;
      apply();
      wait_drained(0, 400, "final_drain_a_timeout");
      wait_drained(1, 400, "final_drain_b_timeout");
      check("final_queue_a_empty", q_a.size(), 0);
      check("final_queue_b_empty", q_b.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hubris_uart_tx_drain.md
Name: hubris_uart_tx_drain

Overview:
Downstream consumer of the Hubris core's external output-IO byte buffer. Pops one byte at a time through the io_output_en / io_output_data / io_buffer_size_avai interface and serialises it as an 8N1 UART frame on a single TX line. On hardware it replaces the simulation-only $write sink, so program console output reaches a physical UART. Also reports a drained status, so a bench or top level can wait for all console output after halt.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
COUNT_WIDTH, 32, width of the bytes_sent statistics counter

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
io_buffer_size_avai  input  32  byte count in the Hubris output buffer; non-zero means io_output_data is valid
io_output_data  input  8  head byte of the Hubris output buffer
io_output_en  output  1  pop strobe to Hubris; the byte is consumed at the rising edge where this is 1
uart_tx  output  1  serial TX line; idle high
busy  output  1  1 while a frame is being shifted (START, DATA or STOP)
drained  output  1  1 when state is IDLE and io_buffer_size_avai == 0
bytes_sent  output  COUNT_WIDTH  count of completed frames; wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, uart_tx=1, busy=0, bytes_sent=0, baud counter=0, bit index=0, shift register=0. While reset==0, io_output_en is forced to 0 combinationally.
- States:
  - IDLE: line high.
  - START: 1 bit time, line 0.
  - DATA: 8 bit times, LSB first.
  - STOP: 1 bit time, line 1.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - The bit ends in the cycle where the counter == CLKS_PER_BIT-1 ("tick").
- io_output_en is combinational and equals reset && (io_buffer_size_avai != 0) && (state==IDLE || (state==STOP && tick)).
- Pop edge (io_output_en==1):
  - io_output_data is latched into the shift register.
  - Next state is START, with the counter cleared.
  - No other edge may pop.
- Latency: uart_tx goes low in the cycle after the pop edge. A frame is exactly 10*CLKS_PER_BIT clk.
- Back-to-back: a pop on STOP's tick chains frames with zero idle gap.
- Transitions:
  - STOP tick with the buffer empty goes to IDLE.
  - DATA advances the bit index on each tick.
  - After bit 7's tick, DATA goes to STOP.
- bytes_sent increments by 1 on every STOP tick, whether the next state is IDLE or START.
- uart_tx is registered (glitch-free). busy = (state != IDLE).
- io_buffer_size_avai changing mid-frame has no effect until the next pop opportunity.
- Empty buffer: io_output_en is never asserted, and the block stays in IDLE indefinitely.
- Reset mid-frame: the frame is aborted and the line returns high the cycle after the reset edge. The in-flight byte is lost, and bytes_sent is cleared.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, START, DATA, STOP, 2 bits);
  - UART_DATA_BITS = 8;
  - UART_FRAME_BITS = 10.
- One sub-module, uart_baud_counter:
  - inputs: clk, reset, run;
  - output: tick;
  - parameter: CLKS_PER_BIT;
  - counter clears when run==0.
- All other logic sits in the top.

Test Plan:
- CLKS_PER_BIT=4; avai=1, data=0x41 for one pop.
  - Required: one io_output_en pulse.
  - uart_tx sequence (4 clk each): 0, then 1,0,0,0,0,0,1,0, then 1.
  - busy high for 40 clk; bytes_sent=1; drained=1 afterwards.
- Two bytes (0x55, 0xAA) available back-to-back.
  - Required: two pops exactly 40 clk apart.
  - Continuous 80-clk waveform with no extra idle cycle.
  - bytes_sent=2.
- avai=0 for 200 clk after reset.
  - Required: io_output_en never 1, uart_tx constant 1, busy=0, drained=1.
- Reset asserted during DATA bit 3.
  - Required: io_output_en=0 while reset is low.
  - uart_tx=1 and busy=0 from the cycle after the reset edge; bytes_sent=0.
  - After release with avai>0, a fresh frame starts cleanly.
- avai drops from 1 to 0 mid-frame, then returns to 1 after 100 clk.
  - Required: the current frame completes, the block enters IDLE (drained=1).
  - The next pop occurs in the first cycle avai != 0.
- CLKS_PER_BIT=2, bytes_sent preloaded near wrap (COUNT_WIDTH=4, send 17 bytes).
  - Required: bytes_sent wraps to 1.
  - Each frame is 20 clk.
